// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder.
// Accepts one load/store at a time, waits WAIT_CYCLES, then performs the
// access and holds the response until the initiator takes it.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_op_write;
  logic [31:0]   w_op_addr;
  logic [31:0]   w_op_wdata;
  logic [3:0]    w_op_wstrb;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_we;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = req_valid & req_ready;

  // RESP is entered straight from IDLE only when there are no wait states,
  // in which case the request fields have not been latched yet.
  assign w_enter_resp = ((r_state == IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));

  // Select live inputs when committing on the acceptance edge, else the latched copy.
  always_comb begin
    w_op_write = r_write;
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_wstrb = r_wstrb;
    if (r_state == IDLE) begin
      w_op_write = req_write;
      w_op_addr  = req_addr;
      w_op_wdata = req_wdata;
      w_op_wstrb = req_wstrb;
    end
  end

  assign w_err = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_idx = w_op_addr[AW+1:2];
  // Reset gates the commit so a store caught mid-flight never lands.
  assign w_we  = w_enter_resp & w_op_write & ~w_err & ~reset;

  // Storage: byte-enabled write on commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_op_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM, request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_op_write) ? 32'd0 : r_mem[w_idx];
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of load/store vectors on a
// WAIT_CYCLES=2 instance, plus reset-abort and zero-wait back-to-back sequences.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_write = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [3:0]  req_wstrb = 0;

  logic        b_req_valid = 0, b_req_write = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 0, b_rsp_err;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_rdata;
  logic [3:0]  b_req_wstrb = 0;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, rsp_ready held low for v.hold cycles.
  task automatic xact(input vec_t v, input int idx);
    int lat;
    logic [31:0] rd;
    @(negedge clk);
    req_valid = 1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    chk("req_ready_idle", idx, req_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched copy must be used.
    req_valid = 0; req_write = ~v.write; req_addr = 32'h0000_0004;
    req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", idx, lat, 3);
    chk("rdata", idx, rsp_rdata, v.exp_rdata);
    chk("err", idx, rsp_err, v.exp_err);
    rd = rsp_rdata;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", idx, {req_ready, rsp_valid}, 2'b01);
      chk("hold_rdata", idx, rsp_rdata, rd);
      chk("hold_err", idx, rsp_err, v.exp_err);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("done_state", idx, {req_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h64,  32'h0000_0019, 4'hF, 0, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h64,  32'h0,         4'h0, 0, 32'h0000_0019, 1'b0};
    tbl[2]  = '{1'b1, 32'h60,  32'hAABB_CCDD, 4'hF, 0, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 32'h60,  32'h1122_3344, 4'h5, 0, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 32'h60,  32'h0,         4'h0, 5, 32'hAA22_CC44, 1'b0};
    tbl[5]  = '{1'b0, 32'h62,  32'h0,         4'h0, 0, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'h100, 32'h0,         4'h0, 0, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 32'h62,  32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1};
    tbl[8]  = '{1'b1, 32'h0,   32'h0102_0304, 4'hF, 0, 32'h0,         1'b0};
    tbl[9]  = '{1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 32'h0,   32'h0,         4'h0, 0, 32'h0102_0304, 1'b0};
    tbl[11] = '{1'b0, 32'h60,  32'h0,         4'h0, 0, 32'hAA22_CC44, 1'b0};
    tbl[12] = '{1'b1, 32'h60,  32'h1234_5678, 4'h0, 0, 32'h0,         1'b0};
    tbl[13] = '{1'b0, 32'h60,  32'h0,         4'h0, 2, 32'hAA22_CC44, 1'b0};
    tbl[14] = '{1'b1, 32'hFC,  32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b0};
    tbl[15] = '{1'b0, 32'hFC,  32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0};

    // Reset values.
    #3;
    chk("rst_flags", 0, {req_ready, rsp_valid, rsp_err}, 3'b100);
    chk("rst_rdata", 0, rsp_rdata, 0);
    chk("rst_flags_b", 0, {b_req_ready, b_rsp_valid, b_rsp_err}, 3'b100);
    @(negedge clk); @(negedge clk);
    reset = 0;

    for (int i = 0; i < NV; i++) xact(tbl[i], i);

    // Reset during WAIT of a store: outputs drop at once, store never lands.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h64; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    chk("in_wait", 0, {req_ready, rsp_valid}, 2'b00);
    #2 reset = 1;
    #1;
    chk("async_rst_flags", 0, {req_ready, rsp_valid, rsp_err}, 3'b100);
    chk("async_rst_rdata", 0, rsp_rdata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    xact('{1'b0, 32'h64, 32'h0, 4'h0, 0, 32'h0000_0019, 1'b0}, 100);

    // Zero-wait instance: store then back-to-back loads with rsp_ready held high.
    b_rsp_ready = 1;
    @(negedge clk);
    b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h4;
    b_req_wdata = 32'h5A5A_0001; b_req_wstrb = 4'hF;
    @(posedge clk); #1;
    chk("b_store_valid", 0, {b_req_ready, b_rsp_valid, b_rsp_err}, 3'b010);
    b_req_write = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i % 2 == 1) begin
        chk("b_load_state", i, {b_req_ready, b_rsp_valid, b_rsp_err}, 3'b010);
        chk("b_load_rdata", i, b_rsp_rdata, 32'h5A5A_0001);
      end else begin
        chk("b_idle_state", i, {b_req_ready, b_rsp_valid}, 2'b10);
      end
    end
    b_req_valid = 0;
    @(posedge clk); #1;
    chk("b_final", 0, {b_req_ready, b_rsp_valid}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words of storage (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port req_wstrb  input  4  byte enables for store; bit i enables wdata[8i+7:8i].
REQ-010 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 SHALL accept a request on a rising edge where req_valid & req_ready, latching write, addr, wdata, wstrb; inputs are ignored outside acceptance.
REQ-018 SHALL transition IDLE->WAIT on acceptance with wait counter loaded to WAIT_CYCLES-1, or IDLE->RESP directly when WAIT_CYCLES = 0.
REQ-019 SHALL decrement the counter each WAIT cycle, going WAIT->RESP on the edge where counter = 0; rsp_valid first rises WAIT_CYCLES+1 edges after acceptance.
REQ-020 SHALL flag error when latched addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-021 SHALL, on the edge entering RESP with no error, write enabled bytes of latched wdata to word addr[31:2] for a store, or capture that word into rsp_rdata for a load.
REQ-022 SHALL, on error, perform no storage access, set rsp_err = 1 and rsp_rdata = 0.
REQ-023 SHALL treat a store with wstrb = 0 as a successful no-op (rsp_err = 0).
REQ-024 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready = 1; the RESP->IDLE transition occurs on that edge.
REQ-025 SHALL NOT accept a new request on the same edge a response completes; earliest next acceptance is the following edge (one request in flight maximum).
REQ-026 SHALL make a load following a store to the same word return the stored bytes merged with unchanged bytes.

Reset
REQ-027 SHALL, while reset = 1, force state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-028 SHALL abandon any in-flight request on reset; a store not yet committed (reset during WAIT) SHALL NOT modify storage.
REQ-029 SHALL NOT clear storage contents on reset.

Verification
REQ-030 Store addr 0x64 wdata 0x19 wstrb 0xF, then load 0x64, WAIT_CYCLES = 2 -> load rsp_valid on 3rd edge after acceptance, rsp_rdata = 0x00000019, rsp_err = 0.
REQ-031 Store 0xAABBCCDD to 0x60, then store 0x11223344 with wstrb 0x5, then load 0x60 -> rsp_rdata = 0xAA22CC44.
REQ-032 Load addr 0x62 and load addr DEPTH_WORDS*4 -> rsp_err = 1, rsp_rdata = 0, storage unchanged.
REQ-033 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready = 0; assert rsp_ready -> IDLE next edge, req_ready = 1.
REQ-034 WAIT_CYCLES = 0 back-to-back loads, rsp_ready held 1 -> rsp_valid on edge after acceptance, one accepted request every 2 cycles.
REQ-035 Assert reset during WAIT of a store to 0x64 (previous content 0x19) -> outputs at reset values immediately, later load of 0x64 returns 0x19.
